// File: rtl/j2_mem_arbiter.sv
// j2_mem_arbiter: shares one single-port data memory between the core and a host,
// with fixed core priority, host starvation relief and a host burst lock.
module j2_mem_arbiter #(
  parameter int WIDTH = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             active_low_reset,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [15:0]      core_addr,
  input  logic [WIDTH-1:0] core_wdata,
  output logic             core_gnt,
  output logic             core_rvalid,
  output logic [WIDTH-1:0] core_rdata,
  output logic             core_stall,
  input  logic             host_req,
  input  logic             host_we,
  input  logic             host_lock,
  input  logic [15:0]      host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic             host_gnt,
  output logic             host_rvalid,
  output logic [WIDTH-1:0] host_rdata,
  output logic [15:0]      mem_addr,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic {ARB, LOCK} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic locked, starved;
  logic [15:0] addr_q;
  logic [WIDTH-1:0] wdata_q, core_hold, host_hold;
  // A LOCK cycle with host_lock low already arbitrates as ARB.
  always_comb begin
    locked = state == LOCK && host_lock;
    starved = host_req && cnt == CW'(STARVE_LIMIT);
    host_gnt = active_low_reset && host_req && (locked || starved || !core_req);
    core_gnt = active_low_reset && core_req && !locked && !host_gnt;
    state_nx = (locked || (host_gnt && host_lock)) ? LOCK : ARB;
    core_stall = core_req && !core_gnt;
    mem_we = (core_gnt && core_we) || (host_gnt && host_we);
    mem_addr = core_gnt ? core_addr : host_gnt ? host_addr : addr_q;
    mem_wdata = core_gnt ? core_wdata : host_gnt ? host_wdata : wdata_q;
    core_rdata = core_rvalid ? mem_rdata : core_hold;
    host_rdata = host_rvalid ? mem_rdata : host_hold;
  end
  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      state <= ARB;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      core_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      core_hold <= '0;
      host_hold <= '0;
    end else begin
      state <= state_nx;
      cnt <= (host_req && !host_gnt) ? (cnt == CW'(STARVE_LIMIT) ? cnt : CW'(cnt + 1'b1)) : '0;
      addr_q <= mem_addr;
      wdata_q <= mem_wdata;
      core_rvalid <= core_gnt && !core_we;
      host_rvalid <= host_gnt && !host_we;
      core_hold <= core_rdata;
      host_hold <= host_rdata;
    end
  end
endmodule
